uart_mem_dumper: RTL and testbench
==================================

UART_MEM_DUMPER -- requirements
Module: uart_mem_dumper

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter DEPTH_BYTES, default 256, number of bytes dumped per run; multiple of 4, minimum 4.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-007 SHALL have port mem_addr  output  log2(DEPTH_BYTES/4)  word address to the memory read port.
REQ-008 SHALL have port mem_rdata  input  32  word read data; valid one cycle after mem_addr is presented (synchronous read).
REQ-009 SHALL have port TxD  output  1  UART serial out, idle high.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until the last stop bit ends.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-012 SHALL use bit period DIV = CLK_FREQ/BAUD cycles with integer truncation (10416 at defaults); every start, data and stop bit holds TxD for exactly DIV cycles.
REQ-013 SHALL send frames as 8N1: start bit 0, data bits LSB first, one stop bit 1; back-to-back frames carry no idle gap.
REQ-014 SHALL send words little-endian: mem_rdata[7:0] first, then [15:8], [23:16], [31:24].
REQ-015 SHALL read word addresses 0, 1, ... DEPTH_BYTES/4-1 in order, so the byte stream matches the memory image a UART loader consumes.
REQ-016 SHALL implement states IDLE, FETCH, LATCH, START_BIT, DATA_BITS, STOP_BIT.
REQ-017 IDLE: TxD=1, busy=0; start=1 -> FETCH with word address 0 and byte index 0.
REQ-018 FETCH: drive mem_addr for one cycle -> LATCH; LATCH: capture mem_rdata into a 32-bit shift register -> START_BIT.
REQ-019 START_BIT: after DIV cycles -> DATA_BITS with bit counter 0.
REQ-020 DATA_BITS: after DIV cycles per bit, shift; after bit 7 -> STOP_BIT.
REQ-021 STOP_BIT end: if byte index < 3 -> increment, shift word 8 right -> START_BIT; if byte index = 3 and word address < last -> increment address, byte index 0 -> FETCH; otherwise pulse done and return to IDLE.
REQ-022 A FETCH/LATCH pair between words SHALL add exactly 2 cycles of stop-bit-high extension; no other inter-frame delay is allowed.
REQ-023 start SHALL be ignored while busy=1, and in the same cycle that done pulses.
REQ-024 mem_addr SHALL hold its last value outside FETCH; mem_rdata SHALL be sampled only in LATCH.
REQ-025 The word-address counter SHALL NOT wrap; the run ends at the last word.

Reset
REQ-026 With rst_n=0 at a clock edge: state IDLE, TxD=1, busy=0, done=0, mem_addr=0, and all counters and the shift register cleared.
REQ-027 Reset asserted mid-frame SHALL abort the dump; TxD is high from the next edge and the partial byte is not resumed; a later start restarts from word 0.

Verification (simulate with CLK_FREQ=100, BAUD=10 so DIV=10 unless stated)
REQ-028 Reset: rst_n=0 for 3 cycles, then idle 50 cycles -> TxD=1, busy=0, done=0, mem_addr=0 throughout.
REQ-029 DEPTH_BYTES=4, word0=0x00A00293, start pulse -> decoded bytes 0x93, 0x02, 0xA0, 0x00; each bit exactly 10 cycles; one done pulse; busy drops the same cycle done pulses.
REQ-030 DEPTH_BYTES=20, memory = 0x00A00293, 0x00528333, 0x0A5032A3, 0x00503383, 0xFE000EE3 -> 20 bytes in little-endian order; 2-cycle stop extension at each word boundary only; mem_addr sequence 0..4.
REQ-031 Second start pulse during byte 1 of a run -> ignored, byte count unchanged, exactly one done pulse.
REQ-032 rst_n=0 during data bit 3 of byte 2 -> TxD=1 next cycle, busy=0; new start -> stream restarts at byte 0x93.
REQ-033 Default parameters (DIV=10416): one byte 0x55 -> bit edges at 10416-cycle multiples, frame length 104160 cycles.

Source files
------------

// File: rtl/uart_mem_dumper.sv
// Streams DEPTH_BYTES of word memory out an 8N1 UART, little-endian, word 0 first.
// Each bit lasts CLK_FREQ/BAUD cycles; word fetches add 2 stop-high cycles; start is ignored while busy.
module uart_mem_dumper #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int DEPTH_BYTES = 256,
  localparam int AW = (DEPTH_BYTES / 4 > 1) ? $clog2(DEPTH_BYTES / 4) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          TxD,
  output logic          busy,
  output logic          done
);

  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LAST_WORD = DEPTH_BYTES / 4 - 1;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [1:0]    byte_idx, byte_idx_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [31:0]   shreg, shreg_nxt;
  logic          done_nxt;
  logic [7:0]    cur_byte;
  logic          bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      addr     <= '0;
      shreg    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_idx <= byte_idx_nxt;
      addr     <= addr_nxt;
      shreg    <= shreg_nxt;
      done     <= done_nxt;
    end
  end

  assign bit_end  = (div_cnt == DW'(DIV - 1));
  assign cur_byte = shreg[7:0];
  assign mem_addr = addr;
  assign busy     = (state != IDLE);

  always_comb begin
    TxD = 1'b1;
    if (state == START_BIT) TxD = 1'b0;
    else if (state == DATA_BITS) TxD = cur_byte[bit_cnt];
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_cnt_nxt  = bit_cnt;
    byte_idx_nxt = byte_idx;
    addr_nxt     = addr;
    shreg_nxt    = shreg;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        // done is high in the first idle cycle; a start there is dropped
        if (start && !done) begin
          state_nxt    = FETCH;
          addr_nxt     = '0;
          byte_idx_nxt = '0;
          bit_cnt_nxt  = '0;
          div_cnt_nxt  = '0;
        end
      end
      FETCH: state_nxt = LATCH;
      LATCH: begin
        shreg_nxt   = mem_rdata;
        div_cnt_nxt = '0;
        state_nxt   = START_BIT;
      end
      START_BIT: begin
        if (bit_end) begin
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = DATA_BITS;
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          div_cnt_nxt = '0;
          if (bit_cnt == 3'd7) state_nxt = STOP_BIT;
          else bit_cnt_nxt = bit_cnt + 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          div_cnt_nxt = '0;
          if (byte_idx != 2'd3) begin
            byte_idx_nxt = byte_idx + 1'b1;
            shreg_nxt    = {8'h00, shreg[31:8]};
            state_nxt    = START_BIT;
          end else if (addr != AW'(LAST_WORD)) begin
            addr_nxt     = addr + 1'b1;
            byte_idx_nxt = '0;
            state_nxt    = FETCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench: decodes the serial stream at DIV=10 and checks bytes, bit widths and word-boundary gaps.
module tb_uart_mem_dumper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        TxD, busy, done;

  logic [31:0] mem [8];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          busy_at_done = 0;
  int          addr_q[$];
  logic [2:0]  prev_addr = '0;

  logic [7:0] exp_b [20] = '{8'h93, 8'h02, 8'hA0, 8'h00,
                             8'h33, 8'h83, 8'h52, 8'h00,
                             8'hA3, 8'h32, 8'h50, 8'h0A,
                             8'h83, 8'h33, 8'h50, 8'h00,
                             8'hE3, 8'h0E, 8'h00, 8'hFE};

  uart_mem_dumper #(.CLK_FREQ(100), .BAUD(10), .DEPTH_BYTES(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .TxD(TxD), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous-read memory model plus a log of address changes
  always @(posedge clk) begin
    if (mem_addr != prev_addr) addr_q.push_back(int'(mem_addr));
    prev_addr = mem_addr;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns one decoded frame, the idle-high cycles before it, and whether every bit held for 10 cycles.
  task automatic rx_byte(input bit poke, output logic [7:0] b, output int gap, output bit len_ok);
    logic       v;
    logic [9:0] slot;
    gap = 0;
    len_ok = 1'b1;
    slot = '0;
    @(negedge clk);
    while (TxD !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      v = TxD;
      slot[s] = v;
      for (int k = 1; k < 10; k++) begin
        if (poke && s == 3 && k == 1) start = 1'b1;
        if (poke && s == 3 && k == 2) start = 1'b0;
        @(negedge clk);
        if (TxD !== v) len_ok = 1'b0;
      end
    end
    if (slot[0] !== 1'b0 || slot[9] !== 1'b1) len_ok = 1'b0;
    b = slot[8:1];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         gap;
    bit         ok;
    int         bad;
    int         d0;

    mem[0] = 32'h00A00293; mem[1] = 32'h00528333; mem[2] = 32'h0A5032A3;
    mem[3] = 32'h00503383; mem[4] = 32'hFE000EE3;
    mem[5] = '0; mem[6] = '0; mem[7] = '0;

    // reset and quiet idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", TxD, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 3'd0) bad++;
    end
    check_eq("idle_stable", bad, 0);

    // full dump with a stray start during byte 1
    addr_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    for (int i = 0; i < 20; i++) begin
      rx_byte(i == 1, b, gap, ok);
      check_eq($sformatf("byte%0d", i), b, exp_b[i]);
      check_eq($sformatf("bitlen%0d", i), ok, 1);
      if (i > 0) check_eq($sformatf("gap%0d", i), gap, (i % 4 == 0) ? 2 : 0);
    end
    for (int w = 0; w < 20 && done_cnt == d0; w++) @(negedge clk);
    check_eq("done_seen", done_cnt - d0, 1);
    check_eq("busy_low_at_done", busy_at_done, 0);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("no_extra_frames", bad, 0);
    check_eq("single_done", done_cnt - d0, 1);
    check_eq("addr_changes", addr_q.size(), 4);
    for (int j = 0; j < addr_q.size() && j < 4; j++)
      check_eq($sformatf("addr_seq%0d", j), addr_q[j], j + 1);

    // abort during data bit 3 of byte 2, then restart
    d0 = done_cnt;
    pulse_start();
    rx_byte(1'b0, b, gap, ok);
    check_eq("pre_abort_b0", b, 8'h93);
    rx_byte(1'b0, b, gap, ok);
    check_eq("pre_abort_b1", b, 8'h02);
    @(negedge clk);
    check_eq("b2_start_bit", TxD, 0);
    repeat (43) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_txd", TxD, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("abort_quiet", bad, 0);
    check_eq("abort_no_done", done_cnt - d0, 0);
    pulse_start();
    rx_byte(1'b0, b, gap, ok);
    check_eq("restart_b0", b, 8'h93);
    check_eq("restart_len0", ok, 1);
    rx_byte(1'b0, b, gap, ok);
    check_eq("restart_b1", b, 8'h02);
    check_eq("restart_gap1", gap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
